// File: rtl/boot_ram_loader_pkg.sv
// boot_loader_pkg: shared loader state encoding and frame constants
package boot_loader_pkg;
   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_BYTES = 4;
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN  = 3'd1,
      DATA = 3'd2,
      CSUM = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } state_t;
endpackage

// File: rtl/boot_ram_loader_if.sv
// boot_ram_loader_if: byte stream in, RAM write port and status out
interface boot_ram_loader_if #(parameter int AW = 8, parameter int DW = 32) ();
   logic          start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          wen;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW:0]   words_written;
   modport master (output start, in_valid, in_data,
                   input in_ready, wen, waddr, wdata, busy, done, error, words_written);
   modport slave (input start, in_valid, in_data,
                  output in_ready, wen, waddr, wdata, busy, done, error, words_written);
endinterface

// File: rtl/boot_ram_loader_byte_word_assembler.sv
// byte_word_assembler: packs accepted bytes little-endian; word_valid marks the 4th byte
module byte_word_assembler
   import boot_loader_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  din,
   output logic [31:0] word,
   output logic        word_valid
);
   logic [1:0]  cnt;
   logic [23:0] sh;
   assign word_valid = en && cnt == 2'(BYTES_PER_WORD - 1);
   assign word = {din, sh};
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         cnt <= '0;
         sh <= '0;
      end else if (clr)
         cnt <= '0;
      else if (en) begin
         cnt <= cnt + 2'd1;
         sh <= {din, sh[23:8]};
      end
endmodule

// File: rtl/boot_ram_loader.sv
// boot_ram_loader: loads a length/payload/checksum byte frame into the boot RAM write port
module boot_ram_loader
   import boot_loader_pkg::*;
#(
   parameter int RAM_DATA_WIDTH = 32,
   parameter int RAM_ADDR_WIDTH = 8
) (
   input logic             clk,
   input logic             resetn,
   boot_ram_loader_if.slave bus
);
   state_t state, state_n;
   logic [31:0] len, word;
   logic [7:0] csum;
   logic [RAM_ADDR_WIDTH:0] ww;
   logic [RAM_ADDR_WIDTH-1:0] waddr;
   logic [RAM_DATA_WIDTH-1:0] wdata;
   logic wen, wv, busy, acc, go, last;
   assign busy = state == LEN || state == DATA || state == CSUM;
   assign acc = bus.in_valid && busy;
   assign go = bus.start && !busy;
   assign last = 32'(ww) + 32'd1 == len;
   byte_word_assembler u_asm (
      .clk(clk),
      .resetn(resetn),
      .clr(go),
      .en(acc && state != CSUM),
      .din(bus.in_data),
      .word(word),
      .word_valid(wv)
   );
   always_comb begin
      state_n = state;
      case (state)
         LEN:  if (wv) state_n = word == 32'd0 ? CSUM : word > (32'd1 << RAM_ADDR_WIDTH) ? ERR : DATA;
         DATA: if (wv && last) state_n = CSUM;
         CSUM: if (acc) state_n = bus.in_data == csum ? DONE : ERR;
         default: if (go) state_n = LEN;
      endcase
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state <= IDLE;
         len <= '0;
         csum <= '0;
         ww <= '0;
         wen <= 1'b0;
         waddr <= '0;
         wdata <= '0;
      end else begin
         state <= state_n;
         wen <= 1'b0;
         if (go) begin
            csum <= '0;
            ww <= '0;
         end
         if (state == LEN && wv) len <= word;
         if (state == DATA && acc) csum <= csum + bus.in_data;
         // the address is the pre-increment count, so the word count shows the new total during wen
         if (state == DATA && wv) begin
            wen <= 1'b1;
            waddr <= ww[RAM_ADDR_WIDTH-1:0];
            wdata <= word;
            ww <= ww + 1'b1;
         end
      end
   assign bus.in_ready = busy;
   assign bus.busy = busy;
   assign bus.done = state == DONE;
   assign bus.error = state == ERR;
   assign bus.wen = wen;
   assign bus.waddr = waddr;
   assign bus.wdata = wdata;
   assign bus.words_written = ww;
endmodule

// File: tb/tb_boot_ram_loader.sv
// tb_boot_ram_loader: directed frames checked against a byte-level frame model every cycle
module tb_boot_ram_loader;
   logic clk = 0, resetn = 0;
   always #5 clk = ~clk;
   boot_ram_loader_if #(.AW(8), .DW(32)) bus ();
   boot_ram_loader dut (.clk(clk), .resetn(resetn), .bus(bus));
   int checks = 0, failures = 0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask
   bit active, wp;
   int idx, res;
   logic [31:0] nn, wd, pd;
   logic [7:0] cs, pa, d;
   logic [8:0] nw;
   // model: one step per cycle, from inputs stable at the falling edge
   always @(negedge clk) begin
      if (!resetn) begin
         active = 0; wp = 0; idx = 0; res = 0; nn = 0; nw = 0; cs = 0; pa = 0; pd = 0;
      end
      chk("in_ready", bus.in_ready, active);
      chk("busy", bus.busy, active);
      chk("done", bus.done, res == 1);
      chk("error", bus.error, res == 2);
      chk("words_written", bus.words_written, nw);
      chk("wen", bus.wen, wp);
      if (wp) begin
         chk("waddr", bus.waddr, pa);
         chk("wdata", bus.wdata, pd);
      end
      wp = 0;
      if (resetn) begin
         if (bus.start && !active) begin
            active = 1; idx = 0; nn = 0; nw = 0; cs = 0; res = 0;
         end else if (active && bus.in_valid) begin
            d = bus.in_data;
            if (idx < 4) begin
               nn[8*idx +: 8] = d;
               if (idx == 3 && nn > 256) begin active = 0; res = 2; end
            end else if (longint'(idx - 4) < 4 * longint'(nn)) begin
               wd[8*((idx-4)%4) +: 8] = d;
               cs = cs + d;
               if ((idx - 4) % 4 == 3) begin wp = 1; pa = nw[7:0]; pd = wd; nw = nw + 1; end
            end else begin
               active = 0;
               res = d == cs ? 1 : 2;
            end
            idx++;
         end
      end
   end
   logic [7:0] ca[$];
   logic [31:0] cd[$];
   always @(negedge clk) if (resetn && bus.wen) begin ca.push_back(bus.waddr); cd.push_back(bus.wdata); end
   task automatic pulse_start();
      bus.start = 1;
      @(posedge clk); #1;
      bus.start = 0;
   endtask
   task automatic send_byte(input logic [7:0] b, input logic st);
      int t = 0;
      bus.in_valid = 1; bus.in_data = b; bus.start = st;
      @(negedge clk);
      while (!bus.in_ready && t < 20) begin @(negedge clk); t++; end
      if (t == 20) begin checks++; failures++; $display("FAIL accept_timeout act=0 exp=1"); end
      @(posedge clk); #1;
      bus.in_valid = 0; bus.start = 0;
   endtask
   task automatic send_frame(input logic [7:0] f[$], input int gap, input int st_at);
      ca.delete(); cd.delete();
      pulse_start();
      foreach (f[i]) begin
         send_byte(f[i], i == st_at);
         if (gap > 0) begin repeat ($urandom_range(0, gap)) @(posedge clk); #1; end
      end
      repeat (3) @(posedge clk); #1;
   endtask
   task automatic basic_lits(input string nm);
      chk({nm, "_nwrites"}, ca.size(), 2);
      if (ca.size() == 2) begin
         chk({nm, "_a0"}, ca[0], 0); chk({nm, "_d0"}, cd[0], 32'h12345678);
         chk({nm, "_a1"}, ca[1], 1); chk({nm, "_d1"}, cd[1], 32'hDEADBEEF);
      end
      chk({nm, "_ww"}, bus.words_written, 2);
   endtask
   logic [7:0] basic[$], f[$];
   initial begin
      bus.start = 0; bus.in_valid = 0; bus.in_data = 0;
      basic = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
      #1;
      chk("rst_in_ready", bus.in_ready, 0); chk("rst_wen", bus.wen, 0);
      chk("rst_waddr", bus.waddr, 0); chk("rst_wdata", bus.wdata, 0);
      chk("rst_busy", bus.busy, 0); chk("rst_done", bus.done, 0);
      chk("rst_error", bus.error, 0); chk("rst_ww", bus.words_written, 0);
      repeat (3) @(posedge clk); #1;
      resetn = 1;
      @(posedge clk); #1;
      send_frame(basic, 0, -1);
      basic_lits("basic");
      chk("basic_done", bus.done, 1); chk("basic_error", bus.error, 0); chk("basic_busy", bus.busy, 0);
      f = basic; f[12] = 8'h4D;
      send_frame(f, 0, -1);
      chk("badcs_nwrites", ca.size(), 2);
      chk("badcs_error", bus.error, 1); chk("badcs_done", bus.done, 0);
      f = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(f, 0, -1);
      chk("zero_nwrites", ca.size(), 0); chk("zero_done", bus.done, 1); chk("zero_ww", bus.words_written, 0);
      f = '{8'h01, 8'h01, 8'h00, 8'h00};
      send_frame(f, 0, -1);
      chk("over_nwrites", ca.size(), 0); chk("over_error", bus.error, 1); chk("over_in_ready", bus.in_ready, 0);
      send_frame(basic, 5, -1);
      basic_lits("gap");
      chk("gap_done", bus.done, 1);
      f = '{8'h00, 8'h01, 8'h00, 8'h00};
      for (int i = 0; i < 256; i++) begin f.push_back(8'(i)); f.push_back(0); f.push_back(0); f.push_back(0); end
      f.push_back(8'h80);
      send_frame(f, 0, 100);
      chk("full_nwrites", ca.size(), 256);
      if (ca.size() == 256)
         for (int i = 0; i < 256; i++) begin
            if (ca[i] != 8'(i)) chk("full_addr", ca[i], i);
            if (cd[i] != 32'(i)) chk("full_data", cd[i], i);
         end
      chk("full_ww", bus.words_written, 256); chk("full_done", bus.done, 1);
      ca.delete(); cd.delete();
      pulse_start();
      for (int i = 0; i < 10; i++) send_byte(basic[i], 0);
      resetn = 0;
      #1;
      chk("mid_wen", bus.wen, 0); chk("mid_waddr", bus.waddr, 0); chk("mid_wdata", bus.wdata, 0);
      chk("mid_busy", bus.busy, 0); chk("mid_in_ready", bus.in_ready, 0); chk("mid_ww", bus.words_written, 0);
      repeat (3) @(posedge clk); #1;
      chk("mid_nwrites", ca.size(), 1);
      resetn = 1;
      @(posedge clk); #1;
      send_frame(basic, 2, -1);
      basic_lits("reload");
      chk("reload_done", bus.done, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
